// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Pure declarations: no latency and no flow control.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } rx_state_e;

    // Rounded clock divider for one oversample tick.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Character receiver: 2-flop sync, 16x tick, 3-point majority vote, framing FSM.
// Outcome strobes are combinational in the stop-sample tick cycle; no backpressure.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 12_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_data,
    output logic [DATA_BITS-1:0] char,
    output logic                 char_valid,
    output logic                 frm_err,
    output logic                 par_err,
    output logic                 idle_bit_tick,
    output logic                 start_det
);

    localparam int DIV  = calc_div(CLK_HZ, BAUD);
    localparam int CNTW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int BW   = $clog2(DATA_BITS);
    localparam logic [CNTW-1:0] DIV_M1   = CNTW'(DIV - 1);
    localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic            ODD      = (PARITY == int'(PAR_ODD));

    if (DIV < 2) begin : g_div_chk
        $error("uart_rx_byte: CLK_HZ too low for 16x oversampling at BAUD");
    end

    logic                 sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [1:0]           fill_q, fill_d;
    logic                 armed_q, armed_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [3:0]           os_q, os_d;
    rx_state_e            state_q, state_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [1:0]           vote_q, vote_d;
    logic                 par_bad_q, par_bad_d;
    logic                 tick, sample, maj, fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            fill_q    <= '0;
            armed_q   <= 1'b0;
            cnt_q     <= '0;
            os_q      <= '0;
            state_q   <= ST_IDLE;
            bit_q     <= '0;
            shreg_q   <= '0;
            vote_q    <= '0;
            par_bad_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            fill_q    <= fill_d;
            armed_q   <= armed_d;
            cnt_q     <= cnt_d;
            os_q      <= os_d;
            state_q   <= state_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            vote_q    <= vote_d;
            par_bad_q <= par_bad_d;
        end
    end

    always_comb begin
        tick          = (cnt_q == DIV_M1);
        sample        = tick && (os_q == 4'd9);
        maj           = (vote_q[1] & vote_q[0]) | (vote_q[1] & sync2_q) | (vote_q[0] & sync2_q);
        // Edges only count once the line has been seen high after reset.
        fall          = armed_q && prev_q && !sync2_q;
        start_det     = (state_q == ST_IDLE) && fall;
        idle_bit_tick = (state_q == ST_IDLE) && tick && (os_q == 4'd15);
        char          = shreg_q;
        char_valid    = 1'b0;
        frm_err       = 1'b0;
        par_err       = 1'b0;

        sync1_d   = uart_data;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        fill_d    = {fill_q[0], 1'b1};
        armed_d   = armed_q | (fill_q[1] & sync2_q);
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        os_d      = tick ? os_q + 1'b1 : os_q;
        state_d   = state_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        vote_d    = vote_q;
        par_bad_d = par_bad_q;

        if (tick && (os_q == 4'd7 || os_q == 4'd8)) begin
            vote_d = {vote_q[0], sync2_q};
        end

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    os_d    = '0;
                end
            end
            ST_START: begin
                if (sample) begin
                    state_d   = maj ? ST_IDLE : ST_DATA;
                    bit_d     = '0;
                    par_bad_d = 1'b0;
                end
            end
            ST_DATA: begin
                if (sample) begin
                    shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
                    if (bit_q == LAST_BIT) begin
                        state_d = (PARITY != int'(PAR_NONE)) ? ST_PAR : ST_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_PAR: begin
                if (sample) begin
                    par_bad_d = (^shreg_q) ^ maj ^ ODD;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (sample) begin
                    state_d = ST_IDLE;
                    if (!maj) begin
                        frm_err = 1'b1;
                    end else if (par_bad_q) begin
                        par_err = 1'b1;
                    end else begin
                        char_valid = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_rx_frame.sv
// Assembles BYTES received characters into one command word, with idle timeout.
// Outputs are 1-clk pulses one cycle after the stop sample; no backpressure.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 12_000_000,
    parameter int BAUD         = 9600,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int BYTES        = 2,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       uart_data,
    output logic [BYTES*DATA_BITS-1:0] storage,
    output logic                       is_data_ready,
    output logic                       framing_err,
    output logic                       parity_err
);

    localparam int FW = BYTES * DATA_BITS;
    localparam int CW = $clog2(BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_BITS + 1);
    localparam logic [CW-1:0] BYTES_C = CW'(BYTES);
    localparam logic [TW-1:0] TO_C    = TW'(TIMEOUT_BITS);

    logic [DATA_BITS-1:0] char_c;
    logic                 char_vld, frm_c, par_c, idle_tick, start_c;

    logic [FW-1:0] asm_q, asm_d, storage_q, storage_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] to_q, to_d;
    logic          rdy_q, rdy_d, frm_q, frm_d, par_q, par_d;

    uart_rx_byte #(
        .CLK_HZ   (CLK_HZ),
        .BAUD     (BAUD),
        .DATA_BITS(DATA_BITS),
        .PARITY   (PARITY)
    ) u_byte (
        .clk          (clk),
        .rst_n        (rst_n),
        .uart_data    (uart_data),
        .char         (char_c),
        .char_valid   (char_vld),
        .frm_err      (frm_c),
        .par_err      (par_c),
        .idle_bit_tick(idle_tick),
        .start_det    (start_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q     <= '0;
            storage_q <= '0;
            count_q   <= '0;
            to_q      <= '0;
            rdy_q     <= 1'b0;
            frm_q     <= 1'b0;
            par_q     <= 1'b0;
        end else begin
            asm_q     <= asm_d;
            storage_q <= storage_d;
            count_q   <= count_d;
            to_q      <= to_d;
            rdy_q     <= rdy_d;
            frm_q     <= frm_d;
            par_q     <= par_d;
        end
    end

    always_comb begin
        asm_d     = asm_q;
        storage_d = storage_q;
        count_d   = count_q;
        to_d      = to_q;
        rdy_d     = 1'b0;
        frm_d     = frm_c;
        par_d     = par_c;

        // Idle ticks only occur in IDLE, so this never collides with a character outcome.
        if (start_c || count_q == '0) begin
            to_d = '0;
        end else if (idle_tick) begin
            if (to_q + 1'b1 == TO_C) begin
                to_d    = '0;
                count_d = '0;
            end else begin
                to_d = to_q + 1'b1;
            end
        end

        if (frm_c || par_c) begin
            count_d = '0;
        end else if (char_vld) begin
            asm_d[int'(count_q)*DATA_BITS +: DATA_BITS] = char_c;
            if (count_q + 1'b1 == BYTES_C) begin
                storage_d = asm_d;
                rdy_d     = 1'b1;
                count_d   = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    assign storage       = storage_q;
    assign is_data_ready = rdy_q;
    assign framing_err   = frm_q;
    assign parity_err    = par_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
`timescale 1ns/1ps
module tb_uart_rx_frame;

    // 16x oversampling with DIV = 8 keeps a bit at 128 clocks.
    localparam int CLK_HZ   = 1_228_800;
    localparam int BAUD     = 9600;
    localparam int BIT      = 128;
    localparam int BIT_FAST = 125;

    localparam logic [1:0] K_RDY = 2'd0;
    localparam logic [1:0] K_FRM = 2'd1;
    localparam logic [1:0] K_PAR = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        line0 = 1'b1;
    logic        line1 = 1'b1;
    logic [15:0] st0, st1;
    logic        rdy0, frm0, par0, rdy1, frm1, par1;

    uart_rx_frame #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .BYTES(2), .TIMEOUT_BITS(20)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .uart_data(line0), .storage(st0),
        .is_data_ready(rdy0), .framing_err(frm0), .parity_err(par0)
    );

    uart_rx_frame #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1), .BYTES(2), .TIMEOUT_BITS(20)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .uart_data(line1), .storage(st1),
        .is_data_ready(rdy1), .framing_err(frm1), .parity_err(par1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] st;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_ev(input int inst, input logic [1:0] kind, input logic [15:0] st);
        exp_t e;
        e.kind = kind;
        e.st   = st;
        if (inst == 0) q0.push_back(e);
        else           q1.push_back(e);
    endtask

    task automatic mon(input int inst, input logic r, input logic f, input logic p,
                       input logic [15:0] st);
        exp_t       e;
        logic [1:0] k;
        int         depth;
        if (r | f | p) begin
            chk($sformatf("pulse_onehot%0d", inst), $countones({r, f, p}), 1);
            k     = r ? K_RDY : (f ? K_FRM : K_PAR);
            depth = (inst == 0) ? q0.size() : q1.size();
            n_chk++;
            if (depth == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse%0d: got kind %0d storage 0x%0h, required no pulse",
                         inst, k, st);
            end else begin
                e = (inst == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("pulse_kind%0d", inst), k, e.kind);
                chk($sformatf("storage%0d", inst), st, e.st);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, rdy0, frm0, par0, st0);
            mon(1, rdy1, frm1, par1, st1);
        end
    end

    task automatic drive(input int inst, input logic v, input int n);
        if (inst == 0) line0 = v;
        else           line1 = v;
        repeat (n) @(negedge clk);
    endtask

    // par < 0 sends no parity bit; otherwise par[0] is the parity bit sent.
    task automatic send(input int inst, input logic [7:0] d, input int par,
                        input logic stop, input int bt);
        drive(inst, 1'b0, bt);
        for (int i = 0; i < 8; i++) drive(inst, d[i], bt);
        if (par >= 0) drive(inst, par[0], bt);
        drive(inst, stop, bt);
        if (inst == 0) line0 = 1'b1;
        else           line1 = 1'b1;
    endtask

    function automatic int evenp(input logic [7:0] d);
        return int'(^d);
    endfunction

    initial begin
        repeat (90000) @(negedge clk);
        $display("FAIL watchdog: got no finish within 90000 cycles, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_storage0", st0, 16'h0);
        chk("reset_pulses0", {rdy0, frm0, par0}, 3'b000);
        chk("reset_storage1", st1, 16'h0);
        chk("reset_pulses1", {rdy1, frm1, par1}, 3'b000);
        rst_n = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        chk("idle_storage0", st0, 16'h0);
        chk("idle_storage1", st1, 16'h0);

        // Basic 8N1 frame, back-to-back characters.
        expect_ev(0, K_RDY, 16'h1234);
        send(0, 8'h34, -1, 1'b1, BIT);
        send(0, 8'h12, -1, 1'b1, BIT);
        drive(0, 1'b1, 2 * BIT);

        // Even parity: a bad character must also drop the partial frame.
        send(1, 8'h33, evenp(8'h33), 1'b1, BIT);
        expect_ev(1, K_PAR, 16'h0000);
        send(1, 8'hA5, 1, 1'b1, BIT);
        expect_ev(1, K_RDY, 16'h010F);
        send(1, 8'h0F, evenp(8'h0F), 1'b1, BIT);
        send(1, 8'h01, evenp(8'h01), 1'b1, BIT);
        // Bad parity plus low stop: framing wins.
        expect_ev(1, K_FRM, 16'h010F);
        send(1, 8'h5A, 1 - evenp(8'h5A), 1'b0, BIT);
        drive(1, 1'b1, 2 * BIT);

        // Framing error, then a fresh frame.
        expect_ev(0, K_FRM, 16'h1234);
        send(0, 8'h55, -1, 1'b0, BIT);
        drive(0, 1'b1, 2 * BIT);
        expect_ev(0, K_RDY, 16'h1122);
        send(0, 8'h22, -1, 1'b1, BIT);
        send(0, 8'h11, -1, 1'b1, BIT);

        // Timeout discards a stale partial frame; a short gap does not.
        send(0, 8'h77, -1, 1'b1, BIT);
        drive(0, 1'b1, 25 * BIT);
        expect_ev(0, K_RDY, 16'h9988);
        send(0, 8'h88, -1, 1'b1, BIT);
        send(0, 8'h99, -1, 1'b1, BIT);
        send(0, 8'h44, -1, 1'b1, BIT);
        drive(0, 1'b1, 10 * BIT);
        expect_ev(0, K_RDY, 16'h3344);
        send(0, 8'h33, -1, 1'b1, BIT);
        drive(0, 1'b1, 2 * BIT);

        // Short glitch is a false start; then a fast-baud frame.
        drive(0, 1'b0, 3 * 8);
        drive(0, 1'b1, 3 * BIT);
        chk("glitch_storage0", st0, 16'h3344);
        expect_ev(0, K_RDY, 16'h3CC3);
        send(0, 8'hC3, -1, 1'b1, BIT_FAST);
        send(0, 8'h3C, -1, 1'b1, BIT_FAST);
        drive(0, 1'b1, 2 * BIT);

        // Reset mid-character, line held low across release.
        send(0, 8'h66, -1, 1'b1, BIT);
        drive(0, 1'b0, BIT);
        drive(0, 1'b0, BIT);
        drive(0, 1'b1, BIT);
        drive(0, 1'b1, BIT / 2);
        rst_n = 1'b0;
        line0 = 1'b0;
        @(negedge clk);
        chk("midrst_storage0", st0, 16'h0);
        chk("midrst_pulses0", {rdy0, frm0, par0}, 3'b000);
        chk("midrst_storage1", st1, 16'h0);
        repeat (BIT) @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b0, 12 * BIT);
        drive(0, 1'b1, 2 * BIT);
        chk("postrst_storage0", st0, 16'h0);
        expect_ev(0, K_RDY, 16'hEFBE);
        send(0, 8'hBE, -1, 1'b1, BIT);
        send(0, 8'hEF, -1, 1'b1, BIT);

        for (int i = 0; i < 4 * BIT && (q0.size() != 0 || q1.size() != 0); i++) begin
            @(negedge clk);
        end
        chk("pending0", q0.size(), 0);
        chk("pending1", q1.size(), 0);
        chk("final_storage0", st0, 16'hEFBE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
